// File: rtl/inst_fetch.sv
// Instruction fetch stage: fetches from imem over req/ack, hands off to decode over valid/ready,
// and drives the PC register's next value. Optional perf counters under IFETCH_PERF_EN.
module inst_fetch #(
   parameter int unsigned XLEN = 64,
   parameter int unsigned ILEN = 32
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [XLEN-1:0] pc,
   output logic [XLEN-1:0] pc_next,
   output logic            imem_req,
   output logic [XLEN-1:0] imem_addr,
   input  logic            imem_ack,
   input  logic [ILEN-1:0] imem_rdata,
   output logic            inst_valid,
   output logic [ILEN-1:0] inst,
   output logic [XLEN-1:0] inst_pc,
   input  logic            dec_ready,
   input  logic            branch_taken,
   input  logic [XLEN-1:0] branch_target,
   output logic            misalign_err
`ifdef IFETCH_PERF_EN
   ,
   output logic [31:0]     fetch_count,
   output logic [31:0]     stall_count
`endif
);

   typedef enum logic [1:0] {FETCH, VALID, HALT} state_t;

   state_t state;
   logic   target_misaligned;

   assign target_misaligned = (branch_target[1:0] != 2'b00);

   // Holding pc_next at pc stalls the PC register without a separate enable.
   always_comb begin
      imem_req   = 1'b0;
      inst_valid = 1'b0;
      imem_addr  = pc;
      pc_next    = pc;
      if (rst) begin
         pc_next = '0;
      end else begin
         case (state)
            FETCH: imem_req = 1'b1;
            VALID: begin
               inst_valid = 1'b1;
               if (dec_ready) begin
                  if (!branch_taken)
                     pc_next = inst_pc + XLEN'(4);
                  else if (!target_misaligned)
                     pc_next = branch_target;
               end
            end
            default: ;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state        <= FETCH;
         inst         <= '0;
         inst_pc      <= '0;
         misalign_err <= 1'b0;
      end else begin
         case (state)
            FETCH: begin
               if (imem_ack) begin
                  inst    <= imem_rdata;
                  inst_pc <= pc;
                  state   <= VALID;
               end
            end
            VALID: begin
               if (dec_ready) begin
                  if (branch_taken && target_misaligned) begin
                     misalign_err <= 1'b1;
                     state        <= HALT;
                  end else begin
                     state <= FETCH;
                  end
               end
            end
            HALT:    state <= HALT;
            default: state <= FETCH;
         endcase
      end
   end

`ifdef IFETCH_PERF_EN
   always_ff @(posedge clk) begin
      if (rst) begin
         fetch_count <= '0;
         stall_count <= '0;
      end else begin
         if (inst_valid && dec_ready)
            fetch_count <= fetch_count + 32'd1;
         if ((imem_req && !imem_ack) || (inst_valid && !dec_ready))
            stall_count <= stall_count + 32'd1;
      end
   end
`endif

endmodule
